// File: rtl/cdb_pkg.sv
// Shared types and constants for the common-data-bus producer (cdb_arbiter).
// Default widths here match the cdb_arbiter parameter defaults.
package cdb_pkg;

    localparam int CDB_WIDTH     = 31;
    localparam int CDB_ROB       = 2;

    localparam int SRC_ALU       = 0;
    localparam int SRC_BRANCH    = 1;
    localparam int SRC_LSU       = 2;
    localparam int N_SRC_DEFAULT = 3;

    typedef struct packed {
        logic [CDB_WIDTH:0] result;
        logic [CDB_ROB:0]   rob;
    } cdb_entry_t;

    // Round-robin successor of a winning source index.
    function automatic int rr_next(input int winner, input int n_src);
        return (winner + 1 >= n_src) ? 0 : winner + 1;
    endfunction

endpackage

// File: rtl/cdb_result_queue.sv
// Per-source result FIFO for the CDB arbiter: DEPTH entries, wrap-around
// pointers, flush empties the queue and has priority over push and pop.
module cdb_result_queue
    import cdb_pkg::*;
#(
    parameter int DW    = CDB_WIDTH + CDB_ROB + 2,
    parameter int DEPTH = 2
)(
    input  logic          clk,
    input  logic          reset_n,
    input  logic          i_flush,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic [DW-1:0] i_din,
    output logic          o_full,
    output logic          o_empty,
    output logic [DW-1:0] o_head
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full  && !i_flush;
    assign w_do_pop  = i_pop  && !o_empty && !i_flush;

    // Storage carries no reset; occupancy is tracked solely by r_count.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB producer: per-source result queues, round-robin grant, registered broadcast.
// Optional build macro CDB_CONTENTION_CNT_EN adds the contentionCount output.
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int WIDTH = 31,
    parameter int ROB   = 2,
    parameter int N_SRC = N_SRC_DEFAULT,
    parameter int DEPTH = 2,
    parameter int SRC_W = (N_SRC > 1) ? $clog2(N_SRC) : 1
)(
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        flush,
    input  logic [N_SRC-1:0]            fuValid,
    input  logic [N_SRC-1:0][WIDTH:0]   fuResult,
    input  logic [N_SRC-1:0][ROB:0]     fuRob,
    output logic [N_SRC-1:0]            fuReady,
    output logic                        validBroadcast,
    output logic [WIDTH:0]              result,
    output logic [ROB:0]                robEntry,
    output logic [SRC_W-1:0]            srcId
`ifdef CDB_CONTENTION_CNT_EN
    ,
    output logic [15:0]                 contentionCount
`endif
);

    localparam int DW = WIDTH + ROB + 2;

    logic [N_SRC-1:0]          w_full;
    logic [N_SRC-1:0]          w_empty;
    logic [N_SRC-1:0]          w_push;
    logic [N_SRC-1:0]          w_pop;
    logic [N_SRC-1:0][DW-1:0]  w_head;
    logic                      w_grant;
    logic [SRC_W-1:0]          w_winner;

    logic [SRC_W-1:0]          r_rr_ptr;
    logic                      r_valid;
    logic [WIDTH:0]            r_result;
    logic [ROB:0]              r_rob;
    logic [SRC_W-1:0]          r_src;

    // Ready comes only from registered occupancy: no same-cycle credit on pop.
    assign fuReady = ~w_full;
    assign w_push  = fuValid & ~w_full & {N_SRC{~flush}};

    for (genvar g = 0; g < N_SRC; g++) begin : g_queue
        cdb_result_queue #(
            .DW    (DW),
            .DEPTH (DEPTH)
        ) u_queue (
            .clk     (clk),
            .reset_n (reset_n),
            .i_flush (flush),
            .i_push  (w_push[g]),
            .i_pop   (w_pop[g]),
            .i_din   ({fuResult[g], fuRob[g]}),
            .o_full  (w_full[g]),
            .o_empty (w_empty[g]),
            .o_head  (w_head[g])
        );
    end

    always_comb begin
        w_grant  = 1'b0;
        w_winner = '0;
        for (int off = 0; off < N_SRC; off++) begin
            if (!w_grant && !w_empty[SRC_W'((int'(r_rr_ptr) + off) % N_SRC)]) begin
                w_grant  = 1'b1;
                w_winner = SRC_W'((int'(r_rr_ptr) + off) % N_SRC);
            end
        end
    end

    always_comb begin
        w_pop = '0;
        if (w_grant && !flush) begin
            w_pop[w_winner] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rr_ptr <= '0;
        end else if (flush) begin
            r_rr_ptr <= '0;
        end else if (w_grant) begin
            r_rr_ptr <= SRC_W'(rr_next(int'(w_winner), N_SRC));
        end
    end

    // Payload and srcId hold across idle cycles; only the valid flag drops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid  <= 1'b0;
            r_result <= '0;
            r_rob    <= '0;
            r_src    <= '0;
        end else if (flush) begin
            r_valid  <= 1'b0;
        end else if (w_grant) begin
            r_valid            <= 1'b1;
            {r_result, r_rob}  <= w_head[w_winner];
            r_src              <= w_winner;
        end else begin
            r_valid  <= 1'b0;
        end
    end

    assign validBroadcast = r_valid;
    assign result         = r_result;
    assign robEntry       = r_rob;
    assign srcId          = r_src;

`ifdef CDB_CONTENTION_CNT_EN
    logic [15:0] r_contention;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_contention <= '0;
        end else if (flush) begin
            r_contention <= '0;
        end else if (($countones(~w_empty) >= 2) && (r_contention != 16'hFFFF)) begin
            r_contention <= r_contention + 16'd1;
        end
    end

    assign contentionCount = r_contention;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios plus randomized traffic
// compared each cycle against a queue-based reference model.
module tb_cdb_arbiter;
    import cdb_pkg::*;

    localparam int NS = 3;
    localparam int DP = 2;

    logic              clk;
    logic              reset_n;
    logic              flush;
    logic [NS-1:0]     fuValid;
    logic [NS-1:0][31:0] fuResult;
    logic [NS-1:0][2:0]  fuRob;
    logic [NS-1:0]     fuReady;
    logic              validBroadcast;
    logic [31:0]       result;
    logic [2:0]        robEntry;
    logic [1:0]        srcId;
`ifdef CDB_CONTENTION_CNT_EN
    logic [15:0]       contentionCount;
`endif

    cdb_arbiter dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .flush          (flush),
        .fuValid        (fuValid),
        .fuResult       (fuResult),
        .fuRob          (fuRob),
        .fuReady        (fuReady),
        .validBroadcast (validBroadcast),
        .result         (result),
        .robEntry       (robEntry),
        .srcId          (srcId)
`ifdef CDB_CONTENTION_CNT_EN
        ,
        .contentionCount(contentionCount)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: one queue of accepted entries per source plus broadcast state.
    cdb_entry_t  mq[NS][$];
    int          m_rr;
    logic        m_valid;
    logic [31:0] m_res;
    logic [2:0]  m_rob;
    logic [1:0]  m_src;
    int          m_cc;

    int passed;
    int total;

    function automatic logic [NS-1:0] exp_ready();
        logic [NS-1:0] r;
        for (int i = 0; i < NS; i++) r[i] = (mq[i].size() < DP);
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NS; i++) mq[i].delete();
        m_rr    = 0;
        m_valid = 1'b0;
        m_res   = '0;
        m_rob   = '0;
        m_src   = '0;
        m_cc    = 0;
    endtask

    task automatic idle();
        flush    = 1'b0;
        fuValid  = '0;
        fuResult = '0;
        fuRob    = '0;
    endtask

    // One clock: the model applies the arbitration rules to pre-edge occupancy.
    task automatic advance();
        int pre[NS];
        int w;
        int ne;
        cdb_entry_t e;
        for (int i = 0; i < NS; i++) pre[i] = mq[i].size();
        @(posedge clk);
        if (flush) begin
            for (int i = 0; i < NS; i++) mq[i].delete();
            m_rr    = 0;
            m_valid = 1'b0;
            m_cc    = 0;
        end else begin
            w  = -1;
            ne = 0;
            for (int off = 0; off < NS; off++) begin
                if (w < 0 && pre[(m_rr + off) % NS] > 0) w = (m_rr + off) % NS;
            end
            for (int i = 0; i < NS; i++) if (pre[i] > 0) ne++;
            if (ne >= 2 && m_cc < 65535) m_cc++;
            if (w >= 0) begin
                e       = mq[w].pop_front();
                m_valid = 1'b1;
                m_res   = e.result;
                m_rob   = e.rob;
                m_src   = 2'(w);
                m_rr    = (w + 1) % NS;
            end else begin
                m_valid = 1'b0;
            end
            for (int i = 0; i < NS; i++) begin
                if (fuValid[i] && pre[i] < DP) begin
                    e.result = fuResult[i];
                    e.rob    = fuRob[i];
                    mq[i].push_back(e);
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        idle();
        model_reset();
        #3;
        total++; if (validBroadcast !== 1'b0) $display("FAIL reset_valid: got %b expected 0", validBroadcast); else passed++;
        total++; if (result !== 32'h0) $display("FAIL reset_result: got %h expected 0", result); else passed++;
        total++; if (robEntry !== 3'h0) $display("FAIL reset_rob: got %h expected 0", robEntry); else passed++;
        total++; if (srcId !== 2'h0) $display("FAIL reset_src: got %h expected 0", srcId); else passed++;
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        total++; if (fuReady !== 3'b111) $display("FAIL reset_ready: got %b expected 111", fuReady); else passed++;
`ifdef CDB_CONTENTION_CNT_EN
        total++; if (contentionCount !== 16'h0) $display("FAIL reset_cc: got %h expected 0", contentionCount); else passed++;
`endif
    endtask

    task automatic test_single();
        idle();
        fuValid[1]  = 1'b1;
        fuResult[1] = 32'hDEAD_BEEF;
        fuRob[1]    = 3'd3;
        advance();
        idle();
        total++; if (validBroadcast !== 1'b0) $display("FAIL single_latency: got valid %b expected 0", validBroadcast); else passed++;
        advance();
        total++; if (validBroadcast !== 1'b1) $display("FAIL single_valid: got %b expected 1", validBroadcast); else passed++;
        total++; if (result !== 32'hDEAD_BEEF) $display("FAIL single_result: got %h expected deadbeef", result); else passed++;
        total++; if (robEntry !== 3'd3) $display("FAIL single_rob: got %0d expected 3", robEntry); else passed++;
        total++; if (srcId !== 2'd1) $display("FAIL single_src: got %0d expected 1", srcId); else passed++;
        advance();
        total++; if (validBroadcast !== 1'b0) $display("FAIL single_once: got valid %b expected 0", validBroadcast); else passed++;
    endtask

    task automatic test_contention();
        idle();
        flush = 1'b1;
        advance();
        idle();
        fuValid = 3'b111;
        for (int i = 0; i < NS; i++) begin
            fuResult[i] = $urandom;
            fuRob[i]    = 3'(i);
        end
        advance();
        idle();
        for (int k = 0; k < NS; k++) begin
            advance();
            total++;
            if (validBroadcast !== 1'b1 || srcId !== 2'(k) || robEntry !== 3'(k) || result !== m_res)
                $display("FAIL contention_slot%0d: got v=%b src=%0d rob=%0d res=%h expected v=1 src=%0d rob=%0d res=%h",
                         k, validBroadcast, srcId, robEntry, result, k, k, m_res);
            else passed++;
        end
        advance();
        total++; if (validBroadcast !== 1'b0) $display("FAIL contention_done: got valid %b expected 0", validBroadcast); else passed++;
`ifdef CDB_CONTENTION_CNT_EN
        total++; if (contentionCount !== 16'd2) $display("FAIL contention_cc: got %0d expected 2", contentionCount); else passed++;
`endif
    endtask

    task automatic test_backpressure();
        bit saw_nr2;
        saw_nr2 = 1'b0;
        idle();
        for (int c = 0; c < 16; c++) begin
            fuValid[0] = (c < 8);
            fuValid[1] = (c < 8);
            fuValid[2] = (c < 4);
            for (int i = 0; i < NS; i++) begin
                fuResult[i] = $urandom;
                fuRob[i]    = 3'(c + i);
            end
            total++;
            if (fuReady !== exp_ready()) $display("FAIL bp_ready c%0d: got %b expected %b", c, fuReady, exp_ready()); else passed++;
            if (!fuReady[2]) saw_nr2 = 1'b1;
            advance();
            total++;
            if ({validBroadcast, result, robEntry, srcId} !== {m_valid, m_res, m_rob, m_src})
                $display("FAIL bp_bcast c%0d: got v=%b res=%h rob=%0d src=%0d expected v=%b res=%h rob=%0d src=%0d",
                         c, validBroadcast, result, robEntry, srcId, m_valid, m_res, m_rob, m_src);
            else passed++;
        end
        idle();
        total++; if (saw_nr2 !== 1'b1) $display("FAIL bp_src2_full: got %b expected 1", saw_nr2); else passed++;
    endtask

    task automatic test_flush();
        idle();
        fuValid = 3'b111;
        for (int i = 0; i < NS; i++) begin
            fuResult[i] = $urandom;
            fuRob[i]    = 3'($urandom);
        end
        advance();
        fuValid = 3'b011;
        for (int i = 0; i < NS; i++) fuResult[i] = $urandom;
        advance();
        idle();
        flush   = 1'b1;
        fuValid = 3'b111;
        advance();
        idle();
        for (int c = 0; c < 4; c++) begin
            total++; if (validBroadcast !== 1'b0) $display("FAIL flush_kill c%0d: got valid %b expected 0", c, validBroadcast); else passed++;
            total++; if (fuReady !== 3'b111) $display("FAIL flush_ready c%0d: got %b expected 111", c, fuReady); else passed++;
            advance();
        end
    endtask

    task automatic test_tag_wrap();
        idle();
        fuValid[0]  = 1'b1;
        fuResult[0] = 32'h0000_0007;
        fuRob[0]    = 3'd7;
        advance();
        fuResult[0] = 32'h0000_0100;
        fuRob[0]    = 3'd0;
        advance();
        idle();
        total++; if (validBroadcast !== 1'b1 || robEntry !== 3'd7) $display("FAIL wrap_first: got v=%b rob=%0d expected v=1 rob=7", validBroadcast, robEntry); else passed++;
        advance();
        total++; if (validBroadcast !== 1'b1 || robEntry !== 3'd0 || result !== 32'h100) $display("FAIL wrap_second: got v=%b rob=%0d res=%h expected v=1 rob=0 res=100", validBroadcast, robEntry, result); else passed++;
        advance();
    endtask

    task automatic test_random();
        idle();
        for (int c = 0; c < 400; c++) begin
            fuValid = 3'($urandom);
            flush   = ($urandom_range(0, 24) == 0);
            for (int i = 0; i < NS; i++) begin
                fuResult[i] = $urandom;
                fuRob[i]    = 3'($urandom);
            end
            total++;
            if (fuReady !== exp_ready()) $display("FAIL rand_ready c%0d: got %b expected %b", c, fuReady, exp_ready()); else passed++;
            advance();
            total++;
            if ({validBroadcast, result, robEntry, srcId} !== {m_valid, m_res, m_rob, m_src})
                $display("FAIL rand_bcast c%0d: got v=%b res=%h rob=%0d src=%0d expected v=%b res=%h rob=%0d src=%0d",
                         c, validBroadcast, result, robEntry, srcId, m_valid, m_res, m_rob, m_src);
            else passed++;
`ifdef CDB_CONTENTION_CNT_EN
            total++;
            if (contentionCount !== 16'(m_cc)) $display("FAIL rand_cc c%0d: got %0d expected %0d", c, contentionCount, m_cc); else passed++;
`endif
        end
        idle();
        for (int c = 0; c < 8; c++) advance();
        total++; if (validBroadcast !== 1'b0) $display("FAIL rand_drain: got valid %b expected 0", validBroadcast); else passed++;
    endtask

    task automatic test_async_reset();
        idle();
        fuValid[2]  = 1'b1;
        fuResult[2] = 32'hCAFE_F00D;
        fuRob[2]    = 3'd5;
        advance();
        fuResult[2] = 32'h1234_5678;
        fuRob[2]    = 3'd6;
        advance();
        idle();
        total++; if (validBroadcast !== 1'b1) $display("FAIL arst_pre: got valid %b expected 1", validBroadcast); else passed++;
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        total++;
        if ({validBroadcast, result, robEntry, srcId} !== {1'b0, 32'h0, 3'h0, 2'h0})
            $display("FAIL arst_zero: got v=%b res=%h rob=%0d src=%0d expected all zero", validBroadcast, result, robEntry, srcId);
        else passed++;
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            advance();
            total++; if (validBroadcast !== 1'b0) $display("FAIL arst_stale c%0d: got valid %b expected 0", c, validBroadcast); else passed++;
        end
        total++; if (fuReady !== 3'b111) $display("FAIL arst_ready: got %b expected 111", fuReady); else passed++;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_flush();
        test_tag_wrap();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
